// File: rtl/rename_freelist_maptable.sv
// Dual-issue register rename core.
// It holds a speculative free list of physical registers, plus a speculative
// and a committed alias table. Logical register 0 is never renamed and always
// reads as PRF 0. There is no valid/ready handshake in this block. A rename
// slot is consumed in a cycle only when its instX_valid is high and
// fire = !pause && allocatable && !recover. A commit slot is consumed in
// every cycle in which its commit_valid is high, because the ROB never stalls.
module rename_freelist_maptable #(
  parameter int ARCH_W   = 6,
  parameter int PRF_W    = 7,
  parameter int FL_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              recover,
  input  logic              pause,
  input  logic              inst0_valid,
  input  logic              inst1_valid,
  input  logic              inst0_wen,
  input  logic              inst1_wen,
  input  logic [ARCH_W-1:0] inst0_ars1,
  input  logic [ARCH_W-1:0] inst0_ars2,
  input  logic [ARCH_W-1:0] inst0_ard,
  input  logic [ARCH_W-1:0] inst1_ars1,
  input  logic [ARCH_W-1:0] inst1_ars2,
  input  logic [ARCH_W-1:0] inst1_ard,
  output logic [PRF_W-1:0]  inst0_prs1,
  output logic [PRF_W-1:0]  inst0_prs2,
  output logic [PRF_W-1:0]  inst1_prs1,
  output logic [PRF_W-1:0]  inst1_prs2,
  output logic [PRF_W-1:0]  inst0_prd_new,
  output logic [PRF_W-1:0]  inst1_prd_new,
  output logic [PRF_W-1:0]  inst0_prd_stale,
  output logic [PRF_W-1:0]  inst1_prd_stale,
  output logic              allocatable,
  input  logic              commit_valid_0,
  input  logic              commit_valid_1,
  input  logic              commit_wen_0,
  input  logic              commit_wen_1,
  input  logic [ARCH_W-1:0] commit_ard_0,
  input  logic [ARCH_W-1:0] commit_ard_1,
  input  logic [PRF_W-1:0]  commit_prd_0,
  input  logic [PRF_W-1:0]  commit_prd_1,
  input  logic [PRF_W-1:0]  commit_prd_stale_0,
  input  logic [PRF_W-1:0]  commit_prd_stale_1
);

  localparam int NUM_ARCH = 1 << ARCH_W;
  localparam int FL_W     = $clog2(FL_DEPTH);
  localparam int PTR_W    = FL_W + 1;  // wrap bit + index

  logic [PRF_W-1:0] fifo          [FL_DEPTH];
  logic [PRF_W-1:0] spec_map      [NUM_ARCH];
  logic [PRF_W-1:0] committed_map [NUM_ARCH];
  logic [PRF_W-1:0] spec_map_nxt  [NUM_ARCH];
  logic [PRF_W-1:0] cmap_nxt      [NUM_ARCH];

  logic [PTR_W-1:0] spec_head, commit_head, tail;
  logic [PTR_W-1:0] free_count, head_p1, tail_p1, alloc_cnt, commit_cnt;
  logic [PTR_W-1:0] commit_head_nxt, push1_ptr;
  logic             wen0, wen1, slot0_w, fire, alloc0, alloc1, cmt0, cmt1;
  logic [PRF_W-1:0] raw_new0, raw_new1;

  assign wen0       = inst0_wen && (inst0_ard != '0);
  assign wen1       = inst1_wen && (inst1_ard != '0);
  assign slot0_w    = inst0_valid && wen0;
  assign free_count = tail - spec_head;
  assign allocatable = free_count >= PTR_W'(2);
  assign fire       = !pause && allocatable && !recover;
  assign alloc0     = fire && slot0_w;
  assign alloc1     = fire && inst1_valid && wen1;
  assign alloc_cnt  = PTR_W'(alloc0) + PTR_W'(alloc1);

  assign cmt0       = commit_valid_0 && commit_wen_0 && (commit_ard_0 != '0);
  assign cmt1       = commit_valid_1 && commit_wen_1 && (commit_ard_1 != '0);
  assign commit_cnt = PTR_W'(cmt0) + PTR_W'(cmt1);
  assign commit_head_nxt = commit_head + commit_cnt;

  assign head_p1    = spec_head + PTR_W'(1);
  assign tail_p1    = tail + PTR_W'(1);
  // Slot 1 pushes right behind slot 0 when both free a register.
  assign push1_ptr  = cmt0 ? tail_p1 : tail;

  // Slot 1 takes the next entry only when slot 0 consumes the head.
  assign raw_new0   = fifo[spec_head[FL_W-1:0]];
  assign raw_new1   = slot0_w ? fifo[head_p1[FL_W-1:0]] : raw_new0;

  // Next committed and speculative maps. Slot 1 is younger, so it wins.
  // A recover copies the committed map including this cycle's commits.
  always_comb begin
    for (int i = 0; i < NUM_ARCH; i++) begin
      cmap_nxt[i] = committed_map[i];
      if (cmt0 && commit_ard_0 == ARCH_W'(i)) cmap_nxt[i] = commit_prd_0;
      if (cmt1 && commit_ard_1 == ARCH_W'(i)) cmap_nxt[i] = commit_prd_1;
      spec_map_nxt[i] = spec_map[i];
      if (alloc0 && inst0_ard == ARCH_W'(i)) spec_map_nxt[i] = raw_new0;
      if (alloc1 && inst1_ard == ARCH_W'(i)) spec_map_nxt[i] = raw_new1;
      if (recover) spec_map_nxt[i] = cmap_nxt[i];
    end
  end

  // Rename outputs. Slot 1 sources bypass slot 0's new PRF. All outputs are zero when the list is short.
  always_comb begin
    inst0_prs1      = '0;
    inst0_prs2      = '0;
    inst1_prs1      = '0;
    inst1_prs2      = '0;
    inst0_prd_new   = '0;
    inst1_prd_new   = '0;
    inst0_prd_stale = '0;
    inst1_prd_stale = '0;
    if (allocatable) begin
      inst0_prd_new   = raw_new0;
      inst1_prd_new   = raw_new1;
      inst0_prs1      = spec_map[inst0_ars1];
      inst0_prs2      = spec_map[inst0_ars2];
      inst0_prd_stale = spec_map[inst0_ard];
      inst1_prs1      = (slot0_w && inst1_ars1 == inst0_ard) ? raw_new0 : spec_map[inst1_ars1];
      inst1_prs2      = (slot0_w && inst1_ars2 == inst0_ard) ? raw_new0 : spec_map[inst1_ars2];
      inst1_prd_stale = (slot0_w && inst1_ard  == inst0_ard) ? raw_new0 : spec_map[inst1_ard];
    end
  end

  // Free-list pointers, the stale-PRF pushes, and both alias tables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= PTR_W'(FL_DEPTH);
      for (int k = 0; k < FL_DEPTH; k++) fifo[k] <= PRF_W'(NUM_ARCH + k);
      for (int i = 0; i < NUM_ARCH; i++) begin
        spec_map[i]      <= PRF_W'(i);
        committed_map[i] <= PRF_W'(i);
      end
    end else begin
      if (cmt0) fifo[tail[FL_W-1:0]]      <= commit_prd_stale_0;
      if (cmt1) fifo[push1_ptr[FL_W-1:0]] <= commit_prd_stale_1;
      tail        <= tail + commit_cnt;
      commit_head <= commit_head_nxt;
      spec_head   <= recover ? commit_head_nxt : spec_head + alloc_cnt;
      for (int i = 0; i < NUM_ARCH; i++) begin
        committed_map[i] <= cmap_nxt[i];
        spec_map[i]      <= spec_map_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_rename_freelist_maptable.sv
// Directed bench for rename_freelist_maptable.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled
// 1 time unit after that.
module tb_rename_freelist_maptable;

  logic       clk = 1'b0;
  logic       rst, recover, pause;
  logic       inst0_valid, inst1_valid, inst0_wen, inst1_wen;
  logic [5:0] inst0_ars1, inst0_ars2, inst0_ard, inst1_ars1, inst1_ars2, inst1_ard;
  logic [6:0] inst0_prs1, inst0_prs2, inst1_prs1, inst1_prs2;
  logic [6:0] inst0_prd_new, inst1_prd_new, inst0_prd_stale, inst1_prd_stale;
  logic       allocatable;
  logic       commit_valid_0, commit_valid_1, commit_wen_0, commit_wen_1;
  logic [5:0] commit_ard_0, commit_ard_1;
  logic [6:0] commit_prd_0, commit_prd_1, commit_prd_stale_0, commit_prd_stale_1;

  int checks = 0;
  int failures = 0;

  // Clock generation.
  always #5 clk = ~clk;

  rename_freelist_maptable dut (
    .clk(clk), .rst(rst), .recover(recover), .pause(pause),
    .inst0_valid(inst0_valid), .inst1_valid(inst1_valid),
    .inst0_wen(inst0_wen), .inst1_wen(inst1_wen),
    .inst0_ars1(inst0_ars1), .inst0_ars2(inst0_ars2), .inst0_ard(inst0_ard),
    .inst1_ars1(inst1_ars1), .inst1_ars2(inst1_ars2), .inst1_ard(inst1_ard),
    .inst0_prs1(inst0_prs1), .inst0_prs2(inst0_prs2),
    .inst1_prs1(inst1_prs1), .inst1_prs2(inst1_prs2),
    .inst0_prd_new(inst0_prd_new), .inst1_prd_new(inst1_prd_new),
    .inst0_prd_stale(inst0_prd_stale), .inst1_prd_stale(inst1_prd_stale),
    .allocatable(allocatable),
    .commit_valid_0(commit_valid_0), .commit_valid_1(commit_valid_1),
    .commit_wen_0(commit_wen_0), .commit_wen_1(commit_wen_1),
    .commit_ard_0(commit_ard_0), .commit_ard_1(commit_ard_1),
    .commit_prd_0(commit_prd_0), .commit_prd_1(commit_prd_1),
    .commit_prd_stale_0(commit_prd_stale_0), .commit_prd_stale_1(commit_prd_stale_1)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    recover = 0; pause = 0;
    inst0_valid = 0; inst1_valid = 0; inst0_wen = 0; inst1_wen = 0;
    inst0_ars1 = 0; inst0_ars2 = 0; inst0_ard = 0;
    inst1_ars1 = 0; inst1_ars2 = 0; inst1_ard = 0;
    commit_valid_0 = 0; commit_valid_1 = 0; commit_wen_0 = 0; commit_wen_1 = 0;
    commit_ard_0 = 0; commit_ard_1 = 0; commit_prd_0 = 0; commit_prd_1 = 0;
    commit_prd_stale_0 = 0; commit_prd_stale_1 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic alloc_pair(input logic [5:0] a0, input logic [5:0] a1);
    inst0_valid = 1; inst0_wen = 1; inst0_ard = a0;
    inst1_valid = 1; inst1_wen = 1; inst1_ard = a1;
    tick();
    clear_inputs();
  endtask

  task automatic alloc_one(input logic [5:0] a0);
    inst0_valid = 1; inst0_wen = 1; inst0_ard = a0;
    tick();
    clear_inputs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    inst0_ars1 = 6'd5; inst0_ars2 = 6'd0;
    #1;
    checks++; if (allocatable !== 1'b1) begin failures++; $display("FAIL reset_allocatable got=%0d exp=1", allocatable); end
    checks++; if (inst0_prd_new !== 7'd64) begin failures++; $display("FAIL reset_prd_new got=%0d exp=64", inst0_prd_new); end
    checks++; if (inst0_prs1 !== 7'd5) begin failures++; $display("FAIL reset_map5 got=%0d exp=5", inst0_prs1); end
    checks++; if (inst0_prs2 !== 7'd0) begin failures++; $display("FAIL reset_map0 got=%0d exp=0", inst0_prs2); end
    // Asynchronous reset takes effect without a clock edge.
    clear_inputs();
    alloc_one(6'd9);
    @(negedge clk);
    rst = 1;
    #1;
    checks++; if (inst0_prd_new !== 7'd64) begin failures++; $display("FAIL async_reset_prd_new got=%0d exp=64", inst0_prd_new); end
    rst = 0;
    tick();
  endtask

  task automatic test_single_alloc();
    do_reset();
    inst0_valid = 1; inst0_wen = 1; inst0_ard = 6'd5; inst0_ars1 = 6'd5;
    #1;
    checks++; if (inst0_prs1 !== 7'd5) begin failures++; $display("FAIL single_prs1 got=%0d exp=5", inst0_prs1); end
    checks++; if (inst0_prd_new !== 7'd64) begin failures++; $display("FAIL single_prd_new got=%0d exp=64", inst0_prd_new); end
    checks++; if (inst0_prd_stale !== 7'd5) begin failures++; $display("FAIL single_stale got=%0d exp=5", inst0_prd_stale); end
    tick();
    clear_inputs();
    inst0_ars1 = 6'd5;
    #1;
    checks++; if (inst0_prs1 !== 7'd64) begin failures++; $display("FAIL single_map5_after got=%0d exp=64", inst0_prs1); end
    checks++; if (inst0_prd_new !== 7'd65) begin failures++; $display("FAIL single_next_prd got=%0d exp=65", inst0_prd_new); end
  endtask

  task automatic test_bypass();
    do_reset();
    inst0_valid = 1; inst0_wen = 1; inst0_ard = 6'd3;
    inst1_valid = 1; inst1_wen = 1; inst1_ard = 6'd3; inst1_ars1 = 6'd3; inst1_ars2 = 6'd8;
    #1;
    checks++; if (inst1_prs1 !== 7'd64) begin failures++; $display("FAIL bypass_prs1 got=%0d exp=64", inst1_prs1); end
    checks++; if (inst1_prs2 !== 7'd8) begin failures++; $display("FAIL bypass_prs2_nohit got=%0d exp=8", inst1_prs2); end
    checks++; if (inst1_prd_new !== 7'd65) begin failures++; $display("FAIL bypass_prd_new got=%0d exp=65", inst1_prd_new); end
    checks++; if (inst1_prd_stale !== 7'd64) begin failures++; $display("FAIL bypass_stale got=%0d exp=64", inst1_prd_stale); end
    tick();
    clear_inputs();
    inst0_ars1 = 6'd3;
    #1;
    checks++; if (inst0_prs1 !== 7'd65) begin failures++; $display("FAIL bypass_map3_after got=%0d exp=65", inst0_prs1); end
    checks++; if (inst0_prd_new !== 7'd66) begin failures++; $display("FAIL bypass_next_prd got=%0d exp=66", inst0_prd_new); end
  endtask

  task automatic test_no_write();
    do_reset();
    inst0_valid = 1; inst0_wen = 1; inst0_ard = 6'd0;
    inst1_valid = 1; inst1_wen = 1; inst1_ard = 6'd4;
    #1;
    checks++; if (inst1_prd_new !== 7'd64) begin failures++; $display("FAIL nowrite_ard0_prd1 got=%0d exp=64", inst1_prd_new); end
    tick();
    clear_inputs();
    inst0_valid = 1; inst0_wen = 0; inst0_ard = 6'd5;
    inst1_valid = 1; inst1_wen = 1; inst1_ard = 6'd6;
    #1;
    checks++; if (inst1_prd_new !== 7'd65) begin failures++; $display("FAIL nowrite_wen0_prd1 got=%0d exp=65", inst1_prd_new); end
    checks++; if (inst0_prd_stale !== 7'd5) begin failures++; $display("FAIL nowrite_stale got=%0d exp=5", inst0_prd_stale); end
    tick();
    clear_inputs();
    inst0_ars1 = 6'd4; inst0_ars2 = 6'd5; inst1_ars1 = 6'd6; inst1_ars2 = 6'd0;
    #1;
    checks++; if (inst0_prs1 !== 7'd64) begin failures++; $display("FAIL nowrite_map4 got=%0d exp=64", inst0_prs1); end
    checks++; if (inst0_prs2 !== 7'd5) begin failures++; $display("FAIL nowrite_map5 got=%0d exp=5", inst0_prs2); end
    checks++; if (inst1_prs1 !== 7'd65) begin failures++; $display("FAIL nowrite_map6 got=%0d exp=65", inst1_prs1); end
    checks++; if (inst1_prs2 !== 7'd0) begin failures++; $display("FAIL nowrite_map0 got=%0d exp=0", inst1_prs2); end
    checks++; if (inst0_prd_new !== 7'd66) begin failures++; $display("FAIL nowrite_next_prd got=%0d exp=66", inst0_prd_new); end
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int j = 0; j < 31; j++) alloc_pair(6'd1, 6'd2);
    #1;
    checks++; if (inst0_prd_new !== 7'd126) begin failures++; $display("FAIL exhaust_mid_prd got=%0d exp=126", inst0_prd_new); end
    alloc_one(6'd1);
    inst0_valid = 1; inst0_wen = 1; inst0_ard = 6'd1; inst0_ars1 = 6'd1;
    inst1_valid = 1; inst1_wen = 1; inst1_ard = 6'd2;
    #1;
    checks++; if (allocatable !== 1'b0) begin failures++; $display("FAIL exhaust_allocatable got=%0d exp=0", allocatable); end
    checks++; if (inst0_prd_new !== 7'd0) begin failures++; $display("FAIL exhaust_prd0 got=%0d exp=0", inst0_prd_new); end
    checks++; if (inst1_prd_new !== 7'd0) begin failures++; $display("FAIL exhaust_prd1 got=%0d exp=0", inst1_prd_new); end
    checks++; if (inst0_prs1 !== 7'd0) begin failures++; $display("FAIL exhaust_prs1 got=%0d exp=0", inst0_prs1); end
    checks++; if (inst0_prd_stale !== 7'd0) begin failures++; $display("FAIL exhaust_stale got=%0d exp=0", inst0_prd_stale); end
    tick();
    clear_inputs();
    commit_valid_0 = 1; commit_wen_0 = 1; commit_ard_0 = 6'd1;
    commit_prd_0 = 7'd64; commit_prd_stale_0 = 7'd7;
    tick();
    clear_inputs();
    inst0_valid = 1; inst0_wen = 1; inst0_ard = 6'd1;
    #1;
    checks++; if (allocatable !== 1'b1) begin failures++; $display("FAIL exhaust_refill_allocatable got=%0d exp=1", allocatable); end
    checks++; if (inst0_prd_new !== 7'd127) begin failures++; $display("FAIL exhaust_refill_prd0 got=%0d exp=127", inst0_prd_new); end
    checks++; if (inst1_prd_new !== 7'd7) begin failures++; $display("FAIL exhaust_refill_prd1 got=%0d exp=7", inst1_prd_new); end
    clear_inputs();
  endtask

  task automatic test_pause_recover();
    do_reset();
    alloc_one(6'd2);
    pause = 1;
    inst0_valid = 1; inst0_wen = 1; inst0_ard = 6'd2;
    #1;
    checks++; if (inst0_prd_new !== 7'd65) begin failures++; $display("FAIL pause_prd_driven got=%0d exp=65", inst0_prd_new); end
    checks++; if (inst0_prd_stale !== 7'd64) begin failures++; $display("FAIL pause_stale got=%0d exp=64", inst0_prd_stale); end
    tick();
    clear_inputs();
    inst0_ars1 = 6'd2;
    #1;
    checks++; if (inst0_prs1 !== 7'd64) begin failures++; $display("FAIL pause_map2_held got=%0d exp=64", inst0_prs1); end
    checks++; if (inst0_prd_new !== 7'd65) begin failures++; $display("FAIL pause_head_held got=%0d exp=65", inst0_prd_new); end
    recover = 1;
    inst0_valid = 1; inst0_wen = 1; inst0_ard = 6'd9;
    tick();
    clear_inputs();
    inst0_ars1 = 6'd2; inst0_ars2 = 6'd9;
    #1;
    checks++; if (inst0_prs1 !== 7'd2) begin failures++; $display("FAIL recover_map2 got=%0d exp=2", inst0_prs1); end
    checks++; if (inst0_prs2 !== 7'd9) begin failures++; $display("FAIL recover_map9 got=%0d exp=9", inst0_prs2); end
    checks++; if (inst0_prd_new !== 7'd64) begin failures++; $display("FAIL recover_head got=%0d exp=64", inst0_prd_new); end
  endtask

  task automatic test_commit_recover();
    do_reset();
    alloc_one(6'd2);
    alloc_one(6'd2);
    recover = 1;
    commit_valid_0 = 1; commit_wen_0 = 1; commit_ard_0 = 6'd2;
    commit_prd_0 = 7'd64; commit_prd_stale_0 = 7'd2;
    inst0_valid = 1; inst0_wen = 1; inst0_ard = 6'd2;
    tick();
    clear_inputs();
    inst0_ars1 = 6'd2;
    #1;
    checks++; if (inst0_prs1 !== 7'd64) begin failures++; $display("FAIL cmtrec_map2 got=%0d exp=64", inst0_prs1); end
    checks++; if (inst0_prd_new !== 7'd65) begin failures++; $display("FAIL cmtrec_head got=%0d exp=65", inst0_prd_new); end
    for (int j = 0; j < 31; j++) alloc_pair(6'd3, 6'd4);
    inst0_valid = 1; inst0_wen = 1; inst0_ard = 6'd3;
    #1;
    checks++; if (inst0_prd_new !== 7'd127) begin failures++; $display("FAIL cmtrec_wrap_prd0 got=%0d exp=127", inst0_prd_new); end
    checks++; if (inst1_prd_new !== 7'd2) begin failures++; $display("FAIL cmtrec_wrap_prd1 got=%0d exp=2", inst1_prd_new); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_pair(6'd7, 6'd7);
    recover = 1;
    commit_valid_0 = 1; commit_wen_0 = 1; commit_ard_0 = 6'd7;
    commit_prd_0 = 7'd64; commit_prd_stale_0 = 7'd7;
    commit_valid_1 = 1; commit_wen_1 = 1; commit_ard_1 = 6'd7;
    commit_prd_1 = 7'd65; commit_prd_stale_1 = 7'd64;
    tick();
    clear_inputs();
    inst0_ars1 = 6'd7;
    #1;
    checks++; if (inst0_prs1 !== 7'd65) begin failures++; $display("FAIL b2b_map7_slot1_wins got=%0d exp=65", inst0_prs1); end
    checks++; if (inst0_prd_new !== 7'd66) begin failures++; $display("FAIL b2b_head got=%0d exp=66", inst0_prd_new); end
    for (int j = 0; j < 31; j++) alloc_pair(6'd5, 6'd6);
    inst0_valid = 1; inst0_wen = 1; inst0_ard = 6'd5;
    #1;
    checks++; if (inst0_prd_new !== 7'd7) begin failures++; $display("FAIL b2b_push_order0 got=%0d exp=7", inst0_prd_new); end
    checks++; if (inst1_prd_new !== 7'd64) begin failures++; $display("FAIL b2b_push_order1 got=%0d exp=64", inst1_prd_new); end
    clear_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_inputs();
    rst = 1;
    #2;
    test_reset();
    test_single_alloc();
    test_bypass();
    test_no_write();
    test_exhaust();
    test_pause_recover();
    test_commit_recover();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_freelist_maptable.md
Name: rename_freelist_maptable

Overview:
- Register-rename core for the dual-issue rename stage: speculative free list of physical registers (PRFs) plus speculative and committed register alias tables.
- Each cycle it allocates up to two new PRFs and translates two instructions' sources and destinations.
- Stale PRFs are reclaimed and committed state is updated at commit; speculative state is restored on recover (pipeline flush).
- Sits between decode and dispatch; commit ports are driven by the ROB.

Parameters:
- ARCH_W, 6, logical register index width; NUM_ARCH = 2^ARCH_W = 64.
- PRF_W, 7, physical register index width; NUM_PHYS = 2^PRF_W = 128.
- FL_DEPTH, 64, free-list capacity (NUM_PHYS - NUM_ARCH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- recover  in  1  flush: restore speculative state from committed state.
- pause  in  1  stall rename: no allocation, no map writes.
- inst0_valid / inst1_valid  in  1  slot carries a valid instruction.
- inst0_wen / inst1_wen  in  1  instruction writes a destination register.
- inst0_ars1, inst0_ars2, inst0_ard / inst1_*  in  ARCH_W each  logical sources and destination.
- inst0_prs1, inst0_prs2 / inst1_*  out  PRF_W each  renamed sources.
- inst0_prd_new / inst1_prd_new  out  PRF_W  allocated destination PRF.
- inst0_prd_stale / inst1_prd_stale  out  PRF_W  previous mapping of ard.
- allocatable  out  1  at least two free PRFs available.
- commit_valid_0 / commit_valid_1  in  1  commit slot valid; slot 0 is older.
- commit_wen_0/1  in  1  committed instruction wrote a register.
- commit_ard_0/1  in  ARCH_W  committed logical destination.
- commit_prd_0/1  in  PRF_W  committed new PRF.
- commit_prd_stale_0/1  in  PRF_W  committed stale PRF, to be freed.

Behaviour:
- Effective write: wenX = instX_wen && instX_ard != 0. Logical reg 0 is never renamed and always maps to PRF 0.
- Rename fire: fire = !pause && allocatable && !recover. Slot X allocates iff fire && instX_valid && wenX.
- Free list: circular FIFO of FL_DEPTH entries, with a speculative head, a committed head and a tail. Pointers are 7-bit (wrap bit plus 6-bit index).
  - free_count = tail - spec_head.
  - allocatable = free_count >= 2, combinational.
- PRF selection: inst0_prd_new = fifo[spec_head]. inst1_prd_new = fifo[spec_head+1] if slot 0 writes (wen0 && valid0), else fifo[spec_head].
  - spec_head advances by the number of allocating slots.
  - Outputs are driven whenever allocatable, independent of fire.
- Commit: each commit slot with valid && wen && ard != 0 does all of the following:
  - pushes commit_prd_stale at tail (slot 0 first);
  - advances commit_head by 1;
  - writes committed_map[ard] = commit_prd. If both slots hit the same ard, slot 1 wins.
- Speculative map (combinational reads):
  - instX_prs1/2 = spec_map[ars]; instX_prd_stale = spec_map[ard].
  - Intra-bundle bypass: if slot 0 writes and inst1_ars1, inst1_ars2 or inst1_ard equals inst0_ard, slot 1 sees inst0_prd_new.
  - Read of index 0 returns 0.
- Map write: on fire, slot 0 then slot 1 write spec_map[ard] = prd_new. Same ard: slot 1 wins.
- Recover, registered at the clock edge:
  - spec_head <= commit_head (including this cycle's commit advance);
  - spec_map <= committed_map (including this cycle's commit writes);
  - this cycle's commits are still applied; recover overrides rename.
- When allocatable = 0, all rename outputs read 0.
- Reset (async):
  - spec_map[i] = committed_map[i] = i;
  - fifo[k] = NUM_ARCH + k;
  - spec_head = commit_head = 0; tail = 64, so the list is full;
  - allocatable = 1, and inst0_prd_new = 64 with no stimulus.
- Pause: state is held except commits, which proceed normally.

Test Plan:
- Reset, slot 0 valid and wen with ard=5, ars1=5; slot 1 invalid.
  - Same cycle: prs1=5, prd_new=64, stale=5.
  - Next cycle: spec_map[5]=64 and inst0_prd_new=65.
- Bundle with inst0 ard=3, inst1 ars1=3 and ard=3.
  - inst1 prs1=64, inst1 prd_new=65, inst1 stale=64.
  - Afterwards spec_map[3]=65.
- Writes to ard=0 or wen=0: no allocation, and inst1_prd_new equals inst0's head value.
  - Example: inst0 ard=0 → inst1_prd_new=64.
- Allocate 63 PRFs with no commits → allocatable=0 and all outputs 0.
  - Then commit one with stale=7 → allocatable=1.
- Allocate 64 for ard=2, pulse pause → no state change.
  - Then recover with no commits → spec_map[2]=2 and next allocation returns 64 again.
- Commit ard=2, prd=64, stale=2 with recover in the same cycle.
  - spec_map[2]=64 and the next prd_new=65.
  - PRF 2 is reused after the list wraps.
